fma16_retire: RTL and testbench

- Downstream retirement stage for fma16; one entry per completed operation.
- Holds fma16 results and their flags in a small in-order FIFO with a valid/ready handshake toward the writeback consumer.
- Maintains the architectural sticky exception-flag register (fflags), which software can overwrite.

---
 rtl/fma16_retire.sv | 89 ++++++++
 tb/tb_fma16_retire.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fma16_retire.sv
// Retirement FIFO for fma16 results: in-order buffering toward writeback
// plus the sticky architectural exception-flag register.
module fma16_retire #(
    parameter int FLEN  = 16,
    parameter int DEPTH = 4,
    parameter int TAGW  = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [FLEN-1:0]            in_result,
    input  logic [3:0]                 in_flags,
    input  logic [TAGW-1:0]            in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [FLEN-1:0]            out_result,
    output logic [3:0]                 out_flags,
    output logic [TAGW-1:0]            out_tag,
    output logic [$clog2(DEPTH):0]     count,
    output logic [3:0]                 fflags,
    input  logic                       fflags_we,
    input  logic [3:0]                 fflags_wdata
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CW   = PTRW + 1;

    logic [FLEN-1:0] result_mem_q [DEPTH];
    logic [3:0]      flags_mem_q  [DEPTH];
    logic [TAGW-1:0] tag_mem_q    [DEPTH];

    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [3:0]      fflags_q, fflags_d;
    logic            push, pop;

    // Handshake depends only on registered occupancy, never on in_valid/out_ready.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);

    assign out_result = result_mem_q[rd_ptr_q];
    assign out_flags  = flags_mem_q[rd_ptr_q];
    assign out_tag    = tag_mem_q[rd_ptr_q];
    assign count      = count_q;
    assign fflags     = fflags_q;

    always_comb begin
        push     = in_valid & in_ready;
        pop      = out_valid & out_ready;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTRW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTRW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Exceptions of the accepted entry survive a concurrent software write.
        if (fflags_we) fflags_d = fflags_wdata | (push ? in_flags : 4'b0000);
        else           fflags_d = fflags_q     | (push ? in_flags : 4'b0000);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            fflags_q <= 4'b0000;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fflags_q <= fflags_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            result_mem_q[wr_ptr_q] <= in_result;
            flags_mem_q[wr_ptr_q]  <= in_flags;
            tag_mem_q[wr_ptr_q]    <= in_tag;
        end
    end

endmodule

// File: tb/tb_fma16_retire.sv
// Self-checking bench for fma16_retire: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_fma16_retire;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_result;
    logic [3:0]  in_flags;
    logic [2:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [3:0]  out_flags;
    logic [2:0]  out_tag;
    logic [2:0]  count;
    logic [3:0]  fflags;
    logic        fflags_we;
    logic [3:0]  fflags_wdata;

    typedef struct {
        logic [15:0] r;
        logic [3:0]  f;
        logic [2:0]  t;
    } entry_t;

    entry_t     model_q[$];
    logic [3:0] model_fflags = 4'b0000;
    int         checks_total  = 0;
    int         checks_passed = 0;

    fma16_retire #(.FLEN(16), .DEPTH(DEPTH), .TAGW(3)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_flags(in_flags), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags), .out_tag(out_tag),
        .count(count), .fflags(fflags),
        .fflags_we(fflags_we), .fflags_wdata(fflags_wdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    endtask

    // Called at a negedge: check current state against the model, drive one
    // cycle of inputs, advance the model over the coming edge, return at next negedge.
    task automatic applyStimulus(input logic rst, input logic iv, input logic [15:0] r,
                                 input logic [3:0] f, input logic [2:0] t, input logic ordy,
                                 input logic we, input logic [3:0] wd);
        bit     accept, retire;
        entry_t e;
        checkOutput("count", 32'(count), 32'(model_q.size()));
        checkOutput("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
        checkOutput("in_ready", 32'(in_ready), 32'(model_q.size() < DEPTH));
        checkOutput("fflags", 32'(fflags), 32'(model_fflags));
        if (model_q.size() != 0) begin
            checkOutput("out_result", 32'(out_result), 32'(model_q[0].r));
            checkOutput("out_flags", 32'(out_flags), 32'(model_q[0].f));
            checkOutput("out_tag", 32'(out_tag), 32'(model_q[0].t));
        end
        reset = rst; in_valid = iv; in_result = r; in_flags = f; in_tag = t;
        out_ready = ordy; fflags_we = we; fflags_wdata = wd;
        if (rst) begin
            model_q.delete();
            model_fflags = 4'b0000;
        end else begin
            accept = iv && (model_q.size() < DEPTH);
            retire = ordy && (model_q.size() != 0);
            model_fflags = (we ? wd : model_fflags) | (accept ? f : 4'b0000);
            if (retire) void'(model_q.pop_front());
            if (accept) begin
                e.r = r; e.f = f; e.t = t;
                model_q.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, 3'h0, ordy, 1'b0, 4'h0);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 3'h0, 1'b0, 1'b0, 4'h0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_result = '0; in_flags = '0; in_tag = '0;
        out_ready = 1'b0; fflags_we = 1'b0; fflags_wdata = '0;
        @(posedge clk);
        @(negedge clk);

        // Reset then idle
        doReset();
        idle(1'b0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_fflags", 32'(fflags), 32'd0);

        // Single result, held until taken
        applyStimulus(1'b0, 1'b1, 16'h3C00, 4'b0001, 3'd5, 1'b0, 1'b0, 4'h0);
        checkOutput("single_valid", 32'(out_valid), 32'd1);
        checkOutput("single_result", 32'(out_result), 32'h3C00);
        checkOutput("single_flags", 32'(out_flags), 32'b0001);
        checkOutput("single_tag", 32'(out_tag), 32'd5);
        checkOutput("single_count", 32'(count), 32'd1);
        checkOutput("single_fflags", 32'(fflags), 32'b0001);
        idle(1'b0);
        idle(1'b0);
        checkOutput("single_held", 32'(out_result), 32'h3C00);
        idle(1'b1);
        checkOutput("single_drained", 32'(out_valid), 32'd0);

        // Fill beyond capacity, then drain across pointer wrap
        doReset();
        for (int v = 1; v <= 5; v++)
            applyStimulus(1'b0, 1'b1, 16'(v), 4'h0, 3'(v), 1'b0, 1'b0, 4'h0);
        checkOutput("fill_count", 32'(count), 32'd4);
        checkOutput("fill_in_ready", 32'(in_ready), 32'd0);
        checkOutput("fill_head", 32'(out_result), 32'h0001);
        begin
            int v = 5;
            for (int i = 0; i < 20 && v <= 9; i++) begin
                bit will_accept = (model_q.size() < DEPTH);
                applyStimulus(1'b0, 1'b1, 16'(v), 4'h0, 3'(v), 1'b1, 1'b0, 4'h0);
                if (will_accept) v++;
            end
        end
        for (int i = 0; i < 6; i++) idle(1'b1);
        checkOutput("wrap_empty", 32'(out_valid), 32'd0);

        // Full with simultaneous pop: input rejected, accepted next cycle
        doReset();
        for (int v = 0; v < 4; v++)
            applyStimulus(1'b0, 1'b1, 16'h1000 + 16'(v), 4'h0, 3'(v), 1'b0, 1'b0, 4'h0);
        applyStimulus(1'b0, 1'b1, 16'hABCD, 4'b0010, 3'd7, 1'b1, 1'b0, 4'h0);
        checkOutput("fullpop_count", 32'(count), 32'd3);
        checkOutput("fullpop_fflags", 32'(fflags), 32'd0);
        applyStimulus(1'b0, 1'b1, 16'hABCD, 4'b0010, 3'd7, 1'b0, 1'b0, 4'h0);
        checkOutput("fullpop_refill", 32'(count), 32'd4);
        checkOutput("fullpop_fflags2", 32'(fflags), 32'b0010);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Sticky flags with software write racing a push
        doReset();
        applyStimulus(1'b0, 1'b1, 16'h0100, 4'b1000, 3'd1, 1'b1, 1'b0, 4'h0);
        checkOutput("sticky_1", 32'(fflags), 32'b1000);
        applyStimulus(1'b0, 1'b1, 16'h0200, 4'b0100, 3'd2, 1'b1, 1'b0, 4'h0);
        checkOutput("sticky_2", 32'(fflags), 32'b1100);
        applyStimulus(1'b0, 1'b1, 16'h0300, 4'b0001, 3'd3, 1'b1, 1'b1, 4'b0000);
        checkOutput("sticky_3", 32'(fflags), 32'b0001);
        idle(1'b1);

        // Reset mid-stream discards everything including the reset-cycle push
        doReset();
        for (int v = 0; v < 3; v++)
            applyStimulus(1'b0, 1'b1, 16'h2000 + 16'(v), 4'b0100, 3'(v), 1'b0, 1'b0, 4'h0);
        applyStimulus(1'b1, 1'b1, 16'hDEAD, 4'b1111, 3'd6, 1'b1, 1'b0, 4'h0);
        checkOutput("midrst_count", 32'(count), 32'd0);
        checkOutput("midrst_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_fflags", 32'(fflags), 32'd0);
        idle(1'b1);
        checkOutput("midrst_stay_empty", 32'(out_valid), 32'd0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 79) == 0),
                          ($urandom_range(0, 99) < 60),
                          16'($urandom), 4'($urandom), 3'($urandom),
                          ($urandom_range(0, 99) < 50),
                          ($urandom_range(0, 15) == 0),
                          4'($urandom));
        end
        idle(1'b0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
